// File: rtl/command_frame_decoder_pkg.sv
// Shared constants and state encoding for the command frame decoder.
// Holds the command byte values, the fixed operand addresses used by the
// ALU-with-operands frame, and the FSM state type.
package command_frame_decoder_pkg;

   // Command bytes recognised in IDLE
   localparam int CMD_WRITE           = 'hAA;
   localparam int CMD_READ            = 'hBB;
   localparam int CMD_ALU_OPERANDS    = 'hCC;
   localparam int CMD_ALU_NO_OPERANDS = 'hDD;

   // Register-file locations the ALU reads its operands from
   localparam int OPERAND_A_ADDRESS = 0;
   localparam int OPERAND_B_ADDRESS = 1;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WR_ADDR   = 4'd1,
      ST_WR_DATA   = 4'd2,
      ST_RD_ADDR   = 4'd3,
      ST_RD_ISSUE  = 4'd4,
      ST_OP_A      = 4'd5,
      ST_OP_B      = 4'd6,
      ST_ALU_FUNC  = 4'd7,
      ST_ALU_ISSUE = 4'd8
   } state_t;

endpackage

// File: rtl/command_frame_decoder.sv
// Purpose: parses UART command frames into register-file write/read strobes and ALU starts.
// Latency: write strobe 1 cycle after the data byte; read/ALU strobe 2 cycles after the last byte when response_ready is high.
// Backpressure: read/ALU issue waits for response_ready; bytes arriving while waiting are dropped and flagged on byte_overrun.
//
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   rx_data / rx_data_valid    - received byte and its one-cycle valid pulse
//   rx_error                   - marks the valid byte as corrupted (parity/frame)
//   response_ready             - reply path can take a new reply
//   register_*                 - register-file write/read strobes, address, write data
//   alu_enable / alu_function  - ALU start strobe and function code
//   frame_aborted, unknown_command, byte_overrun - one-cycle status pulses
module command_frame_decoder
   import command_frame_decoder_pkg::*;
#(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDRESS_WIDTH      = 4,
   parameter int ALU_FUNCTION_WIDTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         rx_data,
   input  logic                          rx_data_valid,
   input  logic                          rx_error,
   input  logic                          response_ready,
   output logic                          register_write_enable,
   output logic                          register_read_enable,
   output logic [ADDRESS_WIDTH-1:0]      register_address,
   output logic [DATA_WIDTH-1:0]         register_write_data,
   output logic                          alu_enable,
   output logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
   output logic                          frame_aborted,
   output logic                          unknown_command,
   output logic                          byte_overrun
);

   state_t                          state, state_next;
   logic                            write_enable_next;
   logic                            read_enable_next;
   logic [ADDRESS_WIDTH-1:0]        address_next;
   logic [DATA_WIDTH-1:0]           write_data_next;
   logic                            alu_enable_next;
   logic [ALU_FUNCTION_WIDTH-1:0]   alu_function_next;
   logic                            frame_aborted_next;
   logic                            unknown_command_next;
   logic                            byte_overrun_next;

   logic good_byte;
   logic bad_byte;

   assign good_byte = rx_data_valid && !rx_error;
   assign bad_byte  = rx_data_valid &&  rx_error;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= ST_IDLE;
         register_write_enable <= 1'b0;
         register_read_enable  <= 1'b0;
         register_address      <= '0;
         register_write_data   <= '0;
         alu_enable            <= 1'b0;
         alu_function          <= '0;
         frame_aborted         <= 1'b0;
         unknown_command       <= 1'b0;
         byte_overrun          <= 1'b0;
      end else begin
         state                 <= state_next;
         register_write_enable <= write_enable_next;
         register_read_enable  <= read_enable_next;
         register_address      <= address_next;
         register_write_data   <= write_data_next;
         alu_enable            <= alu_enable_next;
         alu_function          <= alu_function_next;
         frame_aborted         <= frame_aborted_next;
         unknown_command       <= unknown_command_next;
         byte_overrun          <= byte_overrun_next;
      end
   end

   always_comb begin
      // Address, data and function hold; strobes and pulses default low.
      state_next           = state;
      write_enable_next    = 1'b0;
      read_enable_next     = 1'b0;
      address_next         = register_address;
      write_data_next      = register_write_data;
      alu_enable_next      = 1'b0;
      alu_function_next    = alu_function;
      frame_aborted_next   = 1'b0;
      unknown_command_next = 1'b0;
      byte_overrun_next    = 1'b0;

      case (state)
         ST_IDLE: begin
            // Corrupted bytes between frames are simply ignored.
            if (good_byte) begin
               if (rx_data == DATA_WIDTH'(CMD_WRITE))                state_next = ST_WR_ADDR;
               else if (rx_data == DATA_WIDTH'(CMD_READ))            state_next = ST_RD_ADDR;
               else if (rx_data == DATA_WIDTH'(CMD_ALU_OPERANDS))    state_next = ST_OP_A;
               else if (rx_data == DATA_WIDTH'(CMD_ALU_NO_OPERANDS)) state_next = ST_ALU_FUNC;
               else                                                  unknown_command_next = 1'b1;
            end
         end

         ST_WR_ADDR: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               address_next = rx_data[ADDRESS_WIDTH-1:0];
               state_next   = ST_WR_DATA;
            end
         end

         ST_WR_DATA: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               write_data_next   = rx_data;
               write_enable_next = 1'b1;
               state_next        = ST_IDLE;
            end
         end

         ST_RD_ADDR: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               address_next = rx_data[ADDRESS_WIDTH-1:0];
               state_next   = ST_RD_ISSUE;
            end
         end

         ST_RD_ISSUE: begin
            // A byte landing here has nowhere to go; drop it but still issue.
            if (good_byte) byte_overrun_next = 1'b1;
            if (response_ready) begin
               read_enable_next = 1'b1;
               state_next       = ST_IDLE;
            end
         end

         ST_OP_A: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               address_next      = ADDRESS_WIDTH'(OPERAND_A_ADDRESS);
               write_data_next   = rx_data;
               write_enable_next = 1'b1;
               state_next        = ST_OP_B;
            end
         end

         ST_OP_B: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               address_next      = ADDRESS_WIDTH'(OPERAND_B_ADDRESS);
               write_data_next   = rx_data;
               write_enable_next = 1'b1;
               state_next        = ST_ALU_FUNC;
            end
         end

         ST_ALU_FUNC: begin
            if (bad_byte) begin
               frame_aborted_next = 1'b1;
               state_next         = ST_IDLE;
            end else if (good_byte) begin
               alu_function_next = rx_data[ALU_FUNCTION_WIDTH-1:0];
               state_next        = ST_ALU_ISSUE;
            end
         end

         ST_ALU_ISSUE: begin
            if (good_byte) byte_overrun_next = 1'b1;
            if (response_ready) begin
               alu_enable_next = 1'b1;
               state_next      = ST_IDLE;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_command_frame_decoder.sv
// Directed bench for command_frame_decoder: a per-cycle vector table with
// hand-computed registered outputs, plus hand-written sequences for the
// long response_ready stall and reset in the middle of a frame.
module tb_command_frame_decoder;

   typedef struct packed {
      logic       we;
      logic       re;
      logic [3:0] addr;
      logic [7:0] wd;
      logic       ae;
      logic [3:0] af;
      logic       fa;
      logic       uc;
      logic       ov;
   } out_t;

   typedef struct packed {
      logic [7:0] d;
      logic       v;
      logic       e;
      logic       r;
      out_t       exp;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_error;
   logic       response_ready;
   logic       register_write_enable;
   logic       register_read_enable;
   logic [3:0] register_address;
   logic [7:0] register_write_data;
   logic       alu_enable;
   logic [3:0] alu_function;
   logic       frame_aborted;
   logic       unknown_command;
   logic       byte_overrun;

   int total = 0;
   int bad   = 0;

   command_frame_decoder dut (
      .clk                   (clk),
      .reset                 (reset),
      .rx_data               (rx_data),
      .rx_data_valid         (rx_data_valid),
      .rx_error              (rx_error),
      .response_ready        (response_ready),
      .register_write_enable (register_write_enable),
      .register_read_enable  (register_read_enable),
      .register_address      (register_address),
      .register_write_data   (register_write_data),
      .alu_enable            (alu_enable),
      .alu_function          (alu_function),
      .frame_aborted         (frame_aborted),
      .unknown_command       (unknown_command),
      .byte_overrun          (byte_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   out_t act;
   assign act = {register_write_enable, register_read_enable, register_address,
                 register_write_data, alu_enable, alu_function,
                 frame_aborted, unknown_command, byte_overrun};

   function automatic out_t o(input logic we, input logic re, input logic [3:0] addr,
                              input logic [7:0] wd, input logic ae, input logic [3:0] af,
                              input logic fa, input logic uc, input logic ov);
      out_t r;
      r = {we, re, addr, wd, ae, af, fa, uc, ov};
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] d, input logic v, input logic e,
                               input logic r, input out_t x);
      vec_t t;
      t.d = d; t.v = v; t.e = e; t.r = r; t.exp = x;
      return t;
   endfunction

   task automatic check(input string name, input out_t want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h need=%h (we re addr wd ae af fa uc ov)", name, act, want);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0b need=%0b", name, got, want);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
   task automatic step(input logic [7:0] d, input logic v, input logic e, input logic r);
      @(negedge clk);
      rx_data = d; rx_data_valid = v; rx_error = e; response_ready = r;
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];
   int   re_count;

   initial begin
      reset = 1'b1; rx_data = '0; rx_data_valid = 1'b0; rx_error = 1'b0; response_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", o(0,0,4'h0,8'h00,0,4'h0,0,0,0));
      @(negedge clk);
      reset = 1'b0;

      // write AA 05 3C
      tbl.push_back(mk(8'hAA,1,0,0, o(0,0,4'h0,8'h00,0,4'h0,0,0,0)));
      tbl.push_back(mk(8'h05,1,0,0, o(0,0,4'h5,8'h00,0,4'h0,0,0,0)));
      tbl.push_back(mk(8'h3C,1,0,0, o(1,0,4'h5,8'h3C,0,4'h0,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,0, o(0,0,4'h5,8'h3C,0,4'h0,0,0,0)));
      // ALU without operands: DD 01, ready high
      tbl.push_back(mk(8'hDD,1,0,1, o(0,0,4'h5,8'h3C,0,4'h0,0,0,0)));
      tbl.push_back(mk(8'h01,1,0,1, o(0,0,4'h5,8'h3C,0,4'h1,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h5,8'h3C,1,4'h1,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h5,8'h3C,0,4'h1,0,0,0)));
      // ALU with operands: CC 0A 03 02, ready high
      tbl.push_back(mk(8'hCC,1,0,1, o(0,0,4'h5,8'h3C,0,4'h1,0,0,0)));
      tbl.push_back(mk(8'h0A,1,0,1, o(1,0,4'h0,8'h0A,0,4'h1,0,0,0)));
      tbl.push_back(mk(8'h03,1,0,1, o(1,0,4'h1,8'h03,0,4'h1,0,0,0)));
      tbl.push_back(mk(8'h02,1,0,1, o(0,0,4'h1,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h1,8'h03,1,4'h2,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h1,8'h03,0,4'h2,0,0,0)));
      // abort: AA 04 <err> 55
      tbl.push_back(mk(8'hAA,1,0,0, o(0,0,4'h1,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h04,1,0,0, o(0,0,4'h4,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'hFF,1,1,0, o(0,0,4'h4,8'h03,0,4'h2,1,0,0)));
      tbl.push_back(mk(8'h55,1,0,0, o(0,0,4'h4,8'h03,0,4'h2,0,1,0)));
      tbl.push_back(mk(8'h00,0,0,0, o(0,0,4'h4,8'h03,0,4'h2,0,0,0)));
      // errored byte in IDLE is silent
      tbl.push_back(mk(8'h12,1,1,0, o(0,0,4'h4,8'h03,0,4'h2,0,0,0)));
      // overrun: BB 02 ready low, 99, then ready
      tbl.push_back(mk(8'hBB,1,0,0, o(0,0,4'h4,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h02,1,0,0, o(0,0,4'h2,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,0, o(0,0,4'h2,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h99,1,0,0, o(0,0,4'h2,8'h03,0,4'h2,0,0,1)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,1,4'h2,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h2,8'h03,0,4'h2,0,0,0)));
      // overrun coinciding with ready: issue still happens
      tbl.push_back(mk(8'hBB,1,0,0, o(0,0,4'h2,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h03,1,0,0, o(0,0,4'h3,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h77,1,0,1, o(0,1,4'h3,8'h03,0,4'h2,0,0,1)));
      tbl.push_back(mk(8'h00,0,0,0, o(0,0,4'h3,8'h03,0,4'h2,0,0,0)));
      // address upper bits ignored: AA F9 11
      tbl.push_back(mk(8'hAA,1,0,0, o(0,0,4'h3,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'hF9,1,0,0, o(0,0,4'h9,8'h03,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h11,1,0,0, o(1,0,4'h9,8'h11,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h00,0,0,0, o(0,0,4'h9,8'h11,0,4'h2,0,0,0)));
      // 0x00 is not a command
      tbl.push_back(mk(8'h00,1,0,0, o(0,0,4'h9,8'h11,0,4'h2,0,1,0)));
      // error in ALU_FUNC aborts without an ALU start
      tbl.push_back(mk(8'hDD,1,0,1, o(0,0,4'h9,8'h11,0,4'h2,0,0,0)));
      tbl.push_back(mk(8'h07,1,1,1, o(0,0,4'h9,8'h11,0,4'h2,1,0,0)));
      tbl.push_back(mk(8'h00,0,0,1, o(0,0,4'h9,8'h11,0,4'h2,0,0,0)));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].d, tbl[i].v, tbl[i].e, tbl[i].r);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Read BB 07 held off by 20 cycles of response_ready low.
      step(8'hBB, 1, 0, 0);
      step(8'h07, 1, 0, 0);
      check("rd_addr_latched", o(0,0,4'h7,8'h11,0,4'h2,0,0,0));
      re_count = 0;
      for (int i = 0; i < 20; i++) begin
         step(8'h00, 0, 0, 0);
         if (register_read_enable) re_count++;
      end
      check_bit("rd_stall_no_strobe", re_count != 0, 1'b0);
      step(8'h00, 0, 0, 1);
      check("rd_after_ready", o(0,1,4'h7,8'h11,0,4'h2,0,0,0));
      re_count = 0;
      for (int i = 0; i < 5; i++) begin
         step(8'h00, 0, 0, 1);
         if (register_read_enable) re_count++;
      end
      check_bit("rd_exactly_once", re_count != 0, 1'b0);

      // Reset asserted while waiting for write data.
      step(8'hAA, 1, 0, 0);
      step(8'h05, 1, 0, 0);
      check("pre_reset_addr", o(0,0,4'h5,8'h11,0,4'h2,0,0,0));
      @(negedge clk);
      rx_data_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_frame_reset", o(0,0,4'h0,8'h00,0,4'h0,0,0,0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(8'h3C, 1, 0, 0);
      check("no_write_after_reset", o(0,0,4'h0,8'h00,0,4'h0,0,1,0));
      step(8'h00, 0, 0, 0);
      check("idle_after_reset", o(0,0,4'h0,8'h00,0,4'h0,0,0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/command_frame_decoder.md
Name: command_frame_decoder

Overview:
- Receive-side system controller between the UART receiver's synchronized byte stream and the register file / ALU.
- Parses multi-byte command frames and issues single-cycle register-file writes, register-file reads and ALU operations. Supported frames:
  - 0xAA: write.
  - 0xBB: read.
  - 0xCC: ALU with operands.
  - 0xDD: ALU without operands.
- The downstream response/transmit path gates issue of any command that produces a reply, via response_ready.

Parameters:
- DATA_WIDTH, 8: byte width of received data and register data.
- ADDRESS_WIDTH, 4: register file address width (depth 16).
- ALU_FUNCTION_WIDTH, 4: width of the ALU function code.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  DATA_WIDTH  received byte
- rx_data_valid  input  1  one-cycle pulse, rx_data valid
- rx_error  input  1  qualifies rx_data_valid: byte had a parity or frame error
- response_ready  input  1  transmit path able to accept a new reply
- register_write_enable  output  1  one-cycle write strobe
- register_read_enable  output  1  one-cycle read strobe
- register_address  output  ADDRESS_WIDTH  address for read/write
- register_write_data  output  DATA_WIDTH  write data
- alu_enable  output  1  one-cycle ALU start strobe
- alu_function  output  ALU_FUNCTION_WIDTH  ALU function code
- frame_aborted  output  1  one-cycle pulse: frame dropped on rx_error
- unknown_command  output  1  one-cycle pulse: bad command byte in IDLE
- byte_overrun  output  1  one-cycle pulse: byte dropped while waiting to issue

Behaviour:
- All outputs are registered. All outputs are 0 on reset; state is IDLE.
- Reset asserted mid-frame discards the partial frame and returns to IDLE with outputs 0.
- A byte is "good" when rx_data_valid=1 and rx_error=0.
- States and transitions:
  - IDLE:
    - 0xAA -> WR_ADDR.
    - 0xBB -> RD_ADDR.
    - 0xCC -> OP_A.
    - 0xDD -> ALU_FUNC.
    - Any other good byte: stay in IDLE and pulse unknown_command.
  - WR_ADDR: good byte latches register_address = byte[ADDRESS_WIDTH-1:0] (upper bits ignored) -> WR_DATA.
  - WR_DATA: good byte drives register_write_data = byte and register_write_enable = 1 for exactly the next cycle -> IDLE.
  - RD_ADDR: good byte latches the address -> RD_ISSUE.
  - RD_ISSUE:
    - On a clock edge with response_ready=1: register_read_enable = 1 for one cycle -> IDLE.
    - Otherwise wait indefinitely.
  - OP_A: good byte writes operand A at address 0 (write strobe, one cycle) -> OP_B.
  - OP_B: good byte writes operand B at address 1 (write strobe, one cycle) -> ALU_FUNC.
  - ALU_FUNC: good byte latches alu_function = byte[ALU_FUNCTION_WIDTH-1:0] -> ALU_ISSUE.
  - ALU_ISSUE: on an edge with response_ready=1, alu_enable = 1 for one cycle -> IDLE.
- Latency:
  - Write strobe is high in the cycle after the data byte's valid cycle.
  - With response_ready held high, the read or ALU strobe is high 2 cycles after the last frame byte's valid cycle.
- rx_error on a valid byte:
  - In any non-IDLE, non-ISSUE state: abort to IDLE, pulse frame_aborted, issue no strobe.
  - In IDLE: ignored silently.
- Good byte in RD_ISSUE / ALU_ISSUE: byte dropped, byte_overrun pulsed. This also applies when it coincides with response_ready=1; the issue still happens.
- register_address and alu_function hold their last value between strobes. Strobes are never asserted simultaneously.
- rx_data_valid held high for more than one cycle counts as multiple bytes; upstream guarantees single-cycle pulses.

Decomposition:
- Shared package holds:
  - Command constants: CMD_WRITE=0xAA, CMD_READ=0xBB, CMD_ALU_OPERANDS=0xCC, CMD_ALU_NO_OPERANDS=0xDD.
  - Operand addresses: OPERAND_A_ADDRESS=0, OPERAND_B_ADDRESS=1.
  - The state encoding.
- Single module, no sub-module; the FSM and output registers are one block.

Test Plan:
- Bytes AA, 05, 3C -> one-cycle register_write_enable with address 5 and data 0x3C, one cycle after the 0x3C valid; no other strobes.
- Bytes BB, 07 with response_ready=0 for 20 cycles, then 1 -> no read strobe while ready is low; register_read_enable exactly once, address 7, on the cycle after ready rises.
- Bytes CC, 0A, 03, 02 with ready=1 -> write strobes at address 0 (0x0A) then address 1 (0x03); alu_function=2; alu_enable pulse 2 cycles after the 0x02 valid.
- Bytes DD, 01 with ready=1 -> no write strobes; alu_function=1; single alu_enable pulse.
- Bytes AA, 04, then a byte with rx_error=1, then 55 -> frame_aborted pulse, no write, returns to IDLE; 55 pulses unknown_command.
- Bytes BB, 02 with ready=0, then byte 99 -> byte_overrun pulse; later ready=1 gives a read of address 2. Separately, reset asserted during WR_DATA -> all outputs 0 and no write after release.
